frame_write_packer: RTL

Write-side counterpart to the zoomed read-address generator. It accepts the camera pixel stream (one 16-bit RGB565 pixel per strobe, tagged with hcount/vcount) and packs eight consecutive pixels into one 128-bit framebuffer word. It emits each word with its 27-bit DRAM word address and an end-of-frame tlast on an AXI-stream-style valid/ready output, which feeds the DRAM write FIFO. Read and write sides share one framebuffer layout.

---
 rtl/fb_pkg.sv | 33 +++
 rtl/axis_out_reg.sv | 46 ++++
 rtl/frame_write_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry shared by the write packer and the zoomed read generator.
// Pure declarations: no clocked logic, no flow control.
// One framebuffer word holds eight RGB565 pixels of a single line.
package fb_pkg;

    localparam int FB_H_PIXELS       = 1280;
    localparam int FB_V_PIXELS       = 720;
    localparam int PIXELS_PER_WORD   = 8;
    localparam int FB_WORDS_PER_LINE = FB_H_PIXELS / PIXELS_PER_WORD;

    typedef logic [26:0] fb_addr_t;

    typedef enum logic {
        SYNC = 1'b0,
        PACK = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [127:0] data;
        fb_addr_t     addr;
        logic         last;
    } fb_word_t;

    // Row-major word address; zero-extended to 27 bits before the multiply so nothing truncates.
    function automatic fb_addr_t fb_word_addr(
        input logic [9:0]  vcount,
        input logic [7:0]  word_col,
        input int unsigned words_per_line = FB_WORDS_PER_LINE
    );
        return fb_addr_t'(vcount) * fb_addr_t'(words_per_line) + fb_addr_t'(word_col);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready output register carrying a packed framebuffer word.
// Latency: a load in cycle N is visible on tvalid_out in cycle N+1.
// Backpressure: holds stable while tvalid_out && !tready_in; in_rdy is low only then.
module axis_out_reg
    import fb_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     in_vld,
    input  fb_word_t in_dat,
    output logic     in_rdy,
    input  logic     tready_in,
    output logic     tvalid_out,
    output fb_word_t out_dat
);

    logic     vld_q, vld_d;
    fb_word_t dat_q, dat_d;

    always_comb begin
        in_rdy = !vld_q || tready_in;
        vld_d  = vld_q;
        dat_d  = dat_q;
        if (vld_q && tready_in) begin
            vld_d = 1'b0;
        end
        if (in_vld && in_rdy) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign tvalid_out = vld_q;
    assign out_dat    = dat_q;

endmodule

// File: rtl/frame_write_packer.sv
// Packs eight camera pixels into one 128-bit framebuffer word tagged with its DRAM word address.
// Latency: lane-7 strobe in cycle N gives tvalid_out in cycle N+1; one pixel per cycle sustained.
// Backpressure: single output slot; a completed word finding it full is dropped and flagged.
module frame_write_packer
    import fb_pkg::*;
#(
    parameter int H_PIXELS = FB_H_PIXELS,
    parameter int V_PIXELS = FB_V_PIXELS
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           pixel_valid_in,
    input  logic [10:0]    hcount_in,
    input  logic [9:0]     vcount_in,
    input  logic [15:0]    pixel_in,
    input  logic           tready_in,
    output logic           tvalid_out,
    output logic [127:0]   tdata_out,
    output logic [26:0]    addr_out,
    output logic           tlast_out,
    output logic           overflow_out,
    output logic           partial_out
);

    localparam int          WPL     = H_PIXELS / PIXELS_PER_WORD;
    localparam logic [10:0] H_LIM   = 11'(H_PIXELS);
    localparam logic [9:0]  V_LIM   = 10'(V_PIXELS);
    localparam logic [9:0]  V_LAST  = 10'(V_PIXELS - 1);
    localparam logic [7:0]  C_LAST  = 8'(WPL - 1);

    fb_state_t    state_q, state_d;
    logic [7:0]   mask_q, mask_d;
    logic [127:0] asm_q, asm_d;
    logic [9:0]   widx_v_q, widx_v_d;
    logic [7:0]   widx_c_q, widx_c_d;
    logic         overflow_q, overflow_d;
    logic         partial_q, partial_d;

    logic         in_range, take, mismatch;
    logic [2:0]   lane;
    logic [7:0]   col, new_mask;
    logic         word_vld, out_rdy;
    fb_word_t     word_dat, out_dat;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        asm_d      = asm_q;
        widx_v_d   = widx_v_q;
        widx_c_d   = widx_c_q;
        overflow_d = overflow_q;
        partial_d  = partial_q;
        word_vld   = 1'b0;
        mismatch   = 1'b0;
        new_mask   = mask_q;

        lane     = hcount_in[2:0];
        col      = hcount_in[10:3];
        in_range = pixel_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
        // In SYNC only the frame-origin pixel is taken; it then packs like any other lane-0 pixel.
        take     = in_range && ((state_q == PACK) || (hcount_in == 11'd0 && vcount_in == 10'd0));

        if (take) begin
            state_d  = PACK;
            mismatch = (mask_q != 8'd0) && ((vcount_in != widx_v_q) || (col != widx_c_q));
            if (mismatch) begin
                partial_d = 1'b1;
                new_mask  = 8'd0;
            end
            new_mask = new_mask | (8'd1 << lane);
            asm_d[lane*16 +: 16] = pixel_in;
            widx_v_d = vcount_in;
            widx_c_d = col;
            if (lane == 3'd7) begin
                mask_d = 8'd0;
                if (new_mask == 8'hFF) begin
                    word_vld = 1'b1;
                end else begin
                    partial_d = 1'b1;
                end
            end else begin
                mask_d = new_mask;
            end
        end

        word_dat.data = asm_d;
        word_dat.addr = fb_word_addr(vcount_in, col, WPL);
        word_dat.last = (vcount_in == V_LAST) && (col == C_LAST);

        if (word_vld && !out_rdy) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= SYNC;
            mask_q     <= 8'd0;
            asm_q      <= '0;
            widx_v_q   <= 10'd0;
            widx_c_q   <= 8'd0;
            overflow_q <= 1'b0;
            partial_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            asm_q      <= asm_d;
            widx_v_q   <= widx_v_d;
            widx_c_q   <= widx_c_d;
            overflow_q <= overflow_d;
            partial_q  <= partial_d;
        end
    end

    axis_out_reg u_out (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .in_vld     (word_vld),
        .in_dat     (word_dat),
        .in_rdy     (out_rdy),
        .tready_in  (tready_in),
        .tvalid_out (tvalid_out),
        .out_dat    (out_dat)
    );

    assign tdata_out    = out_dat.data;
    assign addr_out     = out_dat.addr;
    assign tlast_out    = out_dat.last;
    assign overflow_out = overflow_q;
    assign partial_out  = partial_q;

endmodule
